// File: rtl/RISCV.sv
// Shared RISC-V pipeline package: datapath width, fetch FSM states and fetch queue entry.
package RISCV;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } fq_entry_t;

    localparam logic [WIDTH-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and full/empty flags.
// Used by fetch_stage for both the in-flight address queue and the fetch queue.
module fetch_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues pipelined imem requests, queues responses in order
// and drops stale ones after a redirect. Define FETCH_PERF_CNT_EN to add stall/flush counters.
module fetch_stage
    import RISCV::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_gnt,
    input  logic             i_imem_rvalid,
    input  logic [WIDTH-1:0] i_imem_rdata,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_instruccion,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus4,
    output logic             o_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      o_stall_cnt,
    output logic [31:0]      o_flush_cnt
`endif
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int DISC_W = 8;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    fetch_state_t      state;
    logic [WIDTH-1:0]  fetch_pc;
    logic [DISC_W-1:0] discard_cnt;

    logic [CNT_W-1:0]  addr_count;
    logic [CNT_W-1:0]  q_count;
    logic              addr_full;
    logic              addr_empty;
    logic              q_full;
    logic              q_empty;
    logic [WIDTH-1:0]  addr_head;
    fq_entry_t         q_push_data;
    fq_entry_t         q_head;

    logic              misaligned;
    logic              deq;
    logic              accept;
    logic              rsp_tracked;
    logic              rsp_discard;
    logic              rsp_push;
    logic [CNT_W:0]    credit_used;
    logic [DISC_W:0]   in_flight;

    assign misaligned = |i_redirect_pc[1:0];
    assign o_valid    = !q_empty && (state != FS_FAULT);
    assign deq        = o_valid && i_ready && !i_redirect;

    // The head leaving this cycle frees its slot, so a 1-cycle memory sustains one fetch per cycle.
    assign credit_used = {1'b0, addr_count} + {1'b0, q_count} - {{CNT_W{1'b0}}, deq};
    assign o_imem_req  = (state == FS_RUN) && !i_redirect && !addr_full && (credit_used < DEPTH_C);
    assign o_imem_addr = fetch_pc;
    assign accept      = o_imem_req && i_imem_gnt;

    // Responses with nothing in flight belong to requests issued before reset and are ignored.
    assign in_flight   = {1'b0, discard_cnt} + (DISC_W+1)'(addr_count);
    assign rsp_tracked = i_imem_rvalid && (in_flight != '0);
    assign rsp_discard = rsp_tracked && (i_redirect || (discard_cnt != '0));
    assign rsp_push    = rsp_tracked && !rsp_discard && !addr_empty && !q_full;
    assign q_push_data = '{instr: i_imem_rdata, pc: addr_head};

    fetch_fifo #(.DATA_W(WIDTH), .DEPTH(FIFO_DEPTH)) u_addr_q (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_redirect),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (rsp_push),
        .head      (addr_head),
        .count     (addr_count),
        .full      (addr_full),
        .empty     (addr_empty)
    );

    fetch_fifo #(.DATA_W($bits(fq_entry_t)), .DEPTH(FIFO_DEPTH)) u_fetch_q (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_redirect),
        .push      (rsp_push),
        .push_data (q_push_data),
        .pop       (deq),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // A redirect turns every in-flight response into a discard, minus one arriving right now.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= FS_BOOT;
            fetch_pc    <= RESET_PC;
            discard_cnt <= '0;
        end else if (i_redirect) begin
            state       <= misaligned ? FS_FAULT : FS_RUN;
            fetch_pc    <= i_redirect_pc;
            discard_cnt <= DISC_W'(in_flight - {{DISC_W{1'b0}}, rsp_tracked});
        end else begin
            if (state == FS_BOOT)
                state <= FS_RUN;
            if (accept)
                fetch_pc <= fetch_pc + WIDTH'(4);
            if (rsp_discard)
                discard_cnt <= discard_cnt - DISC_W'(1);
        end
    end

    assign o_instruccion = o_valid ? q_head.instr : '0;
    assign o_pc          = o_valid ? q_head.pc : RESET_PC;
    assign o_pc_plus4    = o_pc + WIDTH'(4);
    assign o_fault       = (state == FS_FAULT);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (o_valid && !i_ready && (o_stall_cnt != '1))
                o_stall_cnt <= o_stall_cnt + 32'd1;
            if (i_redirect && (o_flush_cnt != '1))
                o_flush_cnt <= o_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small in-order, always-granting imem model.
module tb_fetch_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b1;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_instruccion;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_stall_cnt;
    logic [31:0] o_flush_cnt;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    int cyc = 0;
    int lat = 1;
    int last_due = 0;
    bit track_occ = 1'b0;
    int occ_max = 0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] out_pc_q[$];
    logic [31:0] out_instr_q[$];
    logic [31:0] out_pc4_q[$];
    int          out_cyc_q[$];

    fetch_stage #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instruccion (o_instruccion),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_fault       (o_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] out_pc(input int i);
        if (i >= 0 && i < out_pc_q.size()) return out_pc_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] out_instr(input int i);
        if (i >= 0 && i < out_instr_q.size()) return out_instr_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] out_pc4(input int i);
        if (i >= 0 && i < out_pc4_q.size()) return out_pc4_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int out_cyc(input int i);
        if (i >= 0 && i < out_cyc_q.size()) return out_cyc_q[i];
        return -1000;
    endfunction

    function automatic logic [31:0] req_addr(input int i);
        if (i >= 0 && i < req_addr_q.size()) return req_addr_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int req_cyc(input int i);
        if (i >= 0 && i < req_cyc_q.size()) return req_cyc_q[i];
        return -1000;
    endfunction

    // Memory model and transfer logger, evaluated mid-cycle when all DUT outputs are settled.
    always @(negedge i_clk) begin
        int due;
        cyc++;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        if (!i_rst && o_imem_req && i_imem_gnt) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_due.push_back(due);
            pend_addr.push_back(o_imem_addr);
            req_addr_q.push_back(o_imem_addr);
            req_cyc_q.push_back(cyc);
        end
        if (!i_rst && o_valid && i_ready && !i_redirect) begin
            out_pc_q.push_back(o_pc);
            out_instr_q.push_back(o_instruccion);
            out_pc4_q.push_back(o_pc_plus4);
            out_cyc_q.push_back(cyc);
        end
        if (track_occ && (req_addr_q.size() - out_pc_q.size()) > occ_max)
            occ_max = req_addr_q.size() - out_pc_q.size();
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(posedge i_clk);
        #1;
        i_ready       = rdy;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        int n0;
        int hold_start;
        logic [31:0] exp_pc;
        bit found;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); #1;
        checkOutput("rst_req", 32'(o_imem_req), 32'd0);
        checkOutput("rst_addr", o_imem_addr, 32'h100);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_fault", 32'(o_fault), 32'd0);
        checkOutput("rst_instr", o_instruccion, 32'h0);
        checkOutput("rst_pc", o_pc, 32'h100);
        checkOutput("rst_pc4", o_pc_plus4, 32'h104);

        // Streaming with a 1-cycle memory
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        checkOutput("boot_noreq", 32'(o_imem_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("first_req", 32'(o_imem_req), 32'd1);
        checkOutput("first_addr", o_imem_addr, 32'h100);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("a_req0", req_addr(0), 32'h100);
        checkOutput("a_req1", req_addr(1), 32'h104);
        checkOutput("a_req2", req_addr(2), 32'h108);
        checkOutput("a_req_gap1", 32'(req_cyc(1) - req_cyc(0)), 32'd1);
        checkOutput("a_req_gap2", 32'(req_cyc(2) - req_cyc(1)), 32'd1);
        checkOutput("a_lat", 32'(out_cyc(0) - req_cyc(0)), 32'd2);
        for (int k = 0; k < 5; k++) begin
            checkOutput("a_pc", out_pc(k), 32'h100 + 32'(4 * k));
            checkOutput("a_instr", out_instr(k), mem_word(32'h100 + 32'(4 * k)));
            if (k > 0) checkOutput("a_gap", 32'(out_cyc(k) - out_cyc(k - 1)), 32'd1);
        end
        checkOutput("a_pc4", out_pc4(2), 32'h10C);

        // Backpressure with a 3-cycle memory
        lat = 3;
        exp_pc = 32'h100 + 32'(4 * out_pc_q.size());
        hold_start = out_pc_q.size();
        track_occ = 1'b1;
        repeat (10) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("hold_valid", 32'(o_valid), 32'd1);
            checkOutput("hold_pc", o_pc, exp_pc);
            checkOutput("hold_instr", o_instruccion, mem_word(exp_pc));
        end
        track_occ = 1'b0;
        checkOutput("hold_credit", 32'(occ_max <= 2), 32'd1);
        repeat (14) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("b_progress", 32'(out_pc_q.size() > hold_start + 4), 32'd1);
        for (int k = 0; k < out_pc_q.size(); k++) begin
            checkOutput("b_pc", out_pc(k), 32'h100 + 32'(4 * k));
            checkOutput("b_instr", out_instr(k), mem_word(32'h100 + 32'(4 * k)));
        end

        // Redirect with two requests in flight
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (pend_due.size() == 2) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkOutput("c_two_inflight", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h400);
        checkOutput("c_redir_noreq", 32'(o_imem_req), 32'd0);
        n0 = out_pc_q.size();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("c_new_req", 32'(o_imem_req), 32'd1);
        checkOutput("c_new_addr", o_imem_addr, 32'h400);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("c_pc0", out_pc(n0), 32'h400);
        checkOutput("c_instr0", out_instr(n0), mem_word(32'h400));
        checkOutput("c_pc1", out_pc(n0 + 1), 32'h404);

        // Misaligned redirect, then recovery
        applyStimulus(1'b1, 1'b1, 32'h402);
        checkOutput("d_redir_noreq", 32'(o_imem_req), 32'd0);
        repeat (4) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("d_fault", 32'(o_fault), 32'd1);
            checkOutput("d_noreq", 32'(o_imem_req), 32'd0);
            checkOutput("d_novalid", 32'(o_valid), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 32'h500);
        n0 = out_pc_q.size();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("d_fault_clr", 32'(o_fault), 32'd0);
        checkOutput("d_resume_req", 32'(o_imem_req), 32'd1);
        checkOutput("d_resume_addr", o_imem_addr, 32'h500);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("d_pc0", out_pc(n0), 32'h500);
        checkOutput("d_instr0", out_instr(n0), mem_word(32'h500));

        // PC wrap at the top of the address space
        lat = 1;
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        n0 = out_pc_q.size();
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("e_pc0", out_pc(n0), 32'hFFFF_FFF8);
        checkOutput("e_pc1", out_pc(n0 + 1), 32'hFFFF_FFFC);
        checkOutput("e_pc2", out_pc(n0 + 2), 32'h0000_0000);
        checkOutput("e_pc4_0", out_pc4(n0), 32'hFFFF_FFFC);
        checkOutput("e_pc4_1", out_pc4(n0 + 1), 32'h0000_0000);
        checkOutput("e_instr2", out_instr(n0 + 2), mem_word(32'h0));

        // Reset in the middle of streaming
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(negedge i_clk); #1;
        checkOutput("f_rst_valid", 32'(o_valid), 32'd0);
        checkOutput("f_rst_req", 32'(o_imem_req), 32'd0);
        checkOutput("f_rst_pc", o_pc, 32'h100);
        checkOutput("f_rst_addr", o_imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("f_rst_stall", o_stall_cnt, 32'd0);
        checkOutput("f_rst_flush", o_flush_cnt, 32'd0);
`endif
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        checkOutput("f_boot_noreq", 32'(o_imem_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("f_first_addr", o_imem_addr, 32'h100);
        checkOutput("f_first_req", 32'(o_imem_req), 32'd1);

`ifdef FETCH_PERF_CNT_EN
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (o_valid) found = 1'b1;
        end
        checkOutput("g_valid_seen", 32'(found), 32'd1);
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h200);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h300);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("g_stall_cnt", o_stall_cnt, 32'd5);
        checkOutput("g_flush_cnt", o_flush_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
